// File: rtl/trig_lookup_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// trig_pkg
// Shared types and helpers for the trig lookup arbiter.
//   t_trig_state : FSM state encoding
//   TRIG_W       : width of the sin/cos results and of the table Q
//   rr_pick()    : round-robin winner search (one-hot winner, index, any)
// -----------------------------------------------------------------------------
package trig_pkg;

    localparam int TRIG_W = 16;

    // rr_pick works on a fixed maximum width so that one function serves
    // every legal N_REQ (2..8); callers zero-extend and pass the real count.
    localparam int RR_MAX   = 8;
    localparam int RR_IDX_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD_SIN,
        RD_COS,
        CAP_COS,
        RESP
    } t_trig_state;

    typedef struct packed {
        logic                any;
        logic [RR_IDX_W-1:0] idx;
        logic [RR_MAX-1:0]   win;
    } t_rr_pick;

    // First set bit of req searching upward from ptr, wrapping modulo n.
    function automatic t_rr_pick rr_pick(input logic [RR_MAX-1:0]   req,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int                  n);
        t_rr_pick r;
        int       k;
        r = '0;
        for (int i = 0; i < RR_MAX; i++) begin
            if (i < n && !r.any) begin
                k = (int'(ptr) + i) % n;
                if (req[k]) begin
                    r.any    = 1'b1;
                    r.idx    = RR_IDX_W'(k);
                    r.win[k] = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/trig_lookup_arbiter_if.sv
// -----------------------------------------------------------------------------
// trig_lookup_arbiter_if
// Bundles the requester-side and table-side signals of the trig lookup arbiter.
//   req      : per-requester request level
//   angle    : packed per-requester angle, angle[i] = angle[i*COUNT_SIZE +: COUNT_SIZE]
//   grant    : one-hot acceptance pulse
//   done     : one-hot result-valid pulse
//   sin_out  : sin result, held until next done
//   cos_out  : cos result, held until next done
//   busy     : arbiter not idle
//   tbl_addr : sine table address
//   tbl_q    : sine table data (1-cycle registered read)
// Modports: slave = the arbiter, master = requesters + table side.
// -----------------------------------------------------------------------------
interface trig_lookup_arbiter_if
    import trig_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int COUNT_SIZE = 8
);

    logic [N_REQ-1:0]            req;
    logic [N_REQ*COUNT_SIZE-1:0] angle;
    logic [N_REQ-1:0]            grant;
    logic [N_REQ-1:0]            done;
    logic [TRIG_W-1:0]           sin_out;
    logic [TRIG_W-1:0]           cos_out;
    logic                        busy;
    logic [COUNT_SIZE-1:0]       tbl_addr;
    logic [TRIG_W-1:0]           tbl_q;

    modport slave (
        input  req, angle, tbl_q,
        output grant, done, sin_out, cos_out, busy, tbl_addr
    );

    modport master (
        output req, angle, tbl_q,
        input  grant, done, sin_out, cos_out, busy, tbl_addr
    );

endinterface

// File: rtl/trig_lookup_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector.
//   req     : request vector
//   ptr     : index that has highest priority this round
//   win     : one-hot winner (all zero when no request)
//   win_idx : winner index
//   any     : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import trig_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    t_rr_pick pick;
    logic     unused_pick_bits;

    assign pick    = rr_pick(RR_MAX'(req), RR_IDX_W'(ptr), N_REQ);
    assign win     = pick.win[N_REQ-1:0];
    assign win_idx = pick.idx[IDX_W-1:0];
    assign any     = pick.any;

    // Upper bits of the fixed-width pick are always zero for small N_REQ.
    assign unused_pick_bits = ^pick;

endmodule

// File: rtl/trig_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// trig_lookup_arbiter
// Shares one registered sine table among N_REQ requesters. Each granted
// request reads sin at ADDR = angle and cos at ADDR = angle + QUARTER, then
// returns both with a one-cycle one-hot done pulse. Round-robin arbitration.
//
// Ports:
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : trig_lookup_arbiter_if.slave (req, angle, grant, done,
//            sin_out, cos_out, busy, tbl_addr, tbl_q)
//
// Optional feature (macro TRIG_LOOKUP_CACHE_EN):
//   one-entry result cache; a winner whose angle matches the cached angle
//   skips the table reads and goes straight to RESP (done one cycle after
//   grant). Without the macro every request takes the full sequence.
//
// Timing: grant is combinational in the accepting IDLE cycle G; done,
// sin_out and cos_out are registered and become visible in RESP (G+4).
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | arbitrate; grant winner, latch its index and angle
//   RD_SIN  | tbl_addr = ang_r (sin read issued)
//   RD_COS  | tbl_addr = ang_r + QUARTER; capture sin from tbl_q
//   CAP_COS | capture cos from tbl_q; load outputs, arm done
//   RESP    | done visible; advance round-robin pointer
// -----------------------------------------------------------------------------
module trig_lookup_arbiter
    import trig_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int COUNT_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  resetN,
    trig_lookup_arbiter_if.slave  bus
);

    localparam int                    IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [COUNT_SIZE-1:0] QUARTER = COUNT_SIZE'(2 ** (COUNT_SIZE - 2));

    t_trig_state           state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      idx;
    logic [COUNT_SIZE-1:0] ang_r;
    logic [TRIG_W-1:0]     sin_r;

    logic [N_REQ-1:0]      win;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_any;
    logic [COUNT_SIZE-1:0] win_ang;
    logic [IDX_W-1:0]      rr_next;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (bus.req),
        .ptr     (rr_ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (win_any)
    );

    assign win_ang = bus.angle[int'(win_idx) * COUNT_SIZE +: COUNT_SIZE];
    assign rr_next = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;

    // Gated by resetN so a request held during reset is not shown as accepted.
    assign bus.grant = (state == IDLE && resetN) ? win : '0;
    assign bus.busy  = (state != IDLE);

    always_comb begin
        bus.tbl_addr = '0;
        case (state)
            RD_SIN:  bus.tbl_addr = ang_r;
            RD_COS:  bus.tbl_addr = ang_r + QUARTER;
            default: bus.tbl_addr = '0;
        endcase
    end

`ifdef TRIG_LOOKUP_CACHE_EN
    logic                  c_valid;
    logic [COUNT_SIZE-1:0] c_ang;
    logic [TRIG_W-1:0]     c_sin;
    logic [TRIG_W-1:0]     c_cos;
    logic                  hit;

    assign hit = c_valid && (win_ang == c_ang);

    // Outputs are already final in RESP, so the cache copies them directly.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            c_valid <= 1'b0;
            c_ang   <= '0;
            c_sin   <= '0;
            c_cos   <= '0;
        end else if (state == RESP) begin
            c_valid <= 1'b1;
            c_ang   <= ang_r;
            c_sin   <= bus.sin_out;
            c_cos   <= bus.cos_out;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            idx         <= '0;
            ang_r       <= '0;
            sin_r       <= '0;
            bus.done    <= '0;
            bus.sin_out <= '0;
            bus.cos_out <= '0;
        end else begin
            bus.done <= '0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        idx   <= win_idx;
                        ang_r <= win_ang;
`ifdef TRIG_LOOKUP_CACHE_EN
                        if (hit) begin
                            bus.sin_out <= c_sin;
                            bus.cos_out <= c_cos;
                            bus.done    <= win;
                            state       <= RESP;
                        end else begin
                            state <= RD_SIN;
                        end
`else
                        state <= RD_SIN;
`endif
                    end
                end
                RD_SIN: begin
                    state <= RD_COS;
                end
                RD_COS: begin
                    sin_r <= bus.tbl_q;
                    state <= CAP_COS;
                end
                CAP_COS: begin
                    // cos goes straight into its output register so that
                    // done and both results appear together in RESP.
                    bus.sin_out <= sin_r;
                    bus.cos_out <= bus.tbl_q;
                    bus.done    <= N_REQ'(1) << idx;
                    state       <= RESP;
                end
                RESP: begin
                    rr_ptr <= rr_next;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trig_lookup_arbiter.sv
module tb_trig_lookup_arbiter;

    logic clk;
    logic resetN;
    int   n_checks;
    int   n_err;

    trig_lookup_arbiter_if #(.N_REQ(4), .COUNT_SIZE(8)) ifc ();

    trig_lookup_arbiter #(.N_REQ(4), .COUNT_SIZE(8)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered table stand-in: a few fixed entries, the rest {a, ~a}.
    function automatic logic [15:0] tbl_val(input logic [7:0] a);
        case (a)
            8'd0:    return 16'h0000;
            8'd8:    return 16'h0031;
            8'd64:   return 16'hFFFF;
            8'd200:  return 16'h0005;
            default: return {a, ~a};
        endcase
    endfunction

    always @(posedge clk) ifc.tbl_q <= tbl_val(ifc.tbl_addr);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Start at a negedge with the DUT idle; ends at the negedge of the
    // following IDLE cycle.
    task automatic serve(input logic [3:0] rv, input logic [7:0] a, input int w,
                         input logic [15:0] es, input logic [15:0] ec, input bit hit);
        logic [3:0] oh;
        oh = 4'(1 << w);
        ifc.req   = rv;
        ifc.angle = {4{a}};
        #1;
        check("grant", 32'(ifc.grant), 32'(oh));
        check("busy_idle", 32'(ifc.busy), 32'd0);
        check("addr_idle", 32'(ifc.tbl_addr), 32'd0);
        @(negedge clk);
        ifc.req[w] = 1'b0;
        if (!hit) begin
            check("addr_sin", 32'(ifc.tbl_addr), 32'(a));
            check("grant_pulse", 32'(ifc.grant), 32'd0);
            check("busy_op", 32'(ifc.busy), 32'd1);
            ifc.angle = ~ifc.angle;
            @(negedge clk);
            check("addr_cos", 32'(ifc.tbl_addr), 32'(8'(a + 8'd64)));
            @(negedge clk);
            check("done_early", 32'(ifc.done), 32'd0);
            @(negedge clk);
        end
        check("done", 32'(ifc.done), 32'(oh));
        check("sin_out", 32'(ifc.sin_out), 32'(es));
        check("cos_out", 32'(ifc.cos_out), 32'(ec));
        check("addr_resp", 32'(ifc.tbl_addr), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(ifc.done), 32'd0);
        check("busy_back", 32'(ifc.busy), 32'd0);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        ifc.req = '0;
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  rv;
        logic [7:0]  a;
        int          w;
        logic [15:0] es;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs[6];
    int   order[5];
    logic [15:0] c_sin[4];
    logic [15:0] c_cos[4];
    logic [3:0]  done_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        vecs[0] = '{4'b0001, 8'd0,   0, 16'h0000, 16'hFFFF};
        vecs[1] = '{4'b0100, 8'd200, 2, 16'h0005, 16'h0031};
        vecs[2] = '{4'b1000, 8'd10,  3, 16'h0AF5, 16'h4AB5};
        vecs[3] = '{4'b0010, 8'd255, 1, 16'hFF00, 16'h3FC0};
        vecs[4] = '{4'b0001, 8'd64,  0, 16'hFFFF, 16'h807F};
        vecs[5] = '{4'b0100, 8'd192, 2, 16'hC03F, 16'h0000};
        order   = '{0, 1, 2, 3, 0};
        c_sin   = '{16'h0000, 16'hFFFF, 16'h807F, 16'hC03F};
        c_cos   = '{16'hFFFF, 16'h807F, 16'hC03F, 16'h0000};

        resetN    = 1'b0;
        ifc.req   = 4'b0101;
        ifc.angle = '0;
        #12;
        check("rst_grant", 32'(ifc.grant), 32'd0);
        check("rst_done", 32'(ifc.done), 32'd0);
        check("rst_sin", 32'(ifc.sin_out), 32'd0);
        check("rst_cos", 32'(ifc.cos_out), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_addr", 32'(ifc.tbl_addr), 32'd0);
        ifc.req = '0;
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            serve(vecs[i].rv, vecs[i].a, vecs[i].w, vecs[i].es, vecs[i].ec, 1'b0);

        // Contention: all four held until their own done; requester 0
        // re-requests while 2 and 3 are still waiting.
        do_reset();
        ifc.angle = {8'd192, 8'd128, 8'd64, 8'd0};
        ifc.req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("cont_grant", 32'(ifc.grant), 32'(1 << order[k]));
            repeat (4) @(negedge clk);
            check("cont_done", 32'(ifc.done), 32'(1 << order[k]));
            check("cont_sin", 32'(ifc.sin_out), 32'(c_sin[order[k]]));
            check("cont_cos", 32'(ifc.cos_out), 32'(c_cos[order[k]]));
            ifc.req[order[k]] = 1'b0;
            if (k == 1) ifc.req[0] = 1'b1;
            @(negedge clk);
        end
        check("cont_idle", 32'(ifc.busy), 32'd0);

        // Fairness: pointer moves past the last served requester.
        do_reset();
        serve(4'b0010, 8'd10,  1, 16'h0AF5, 16'h4AB5, 1'b0);
        serve(4'b0011, 8'd255, 0, 16'hFF00, 16'h3FC0, 1'b0);
        serve(4'b0010, 8'd64,  1, 16'hFFFF, 16'h807F, 1'b0);
        serve(4'b1010, 8'd192, 3, 16'hC03F, 16'h0000, 1'b0);

        // Reset during RD_COS, outputs currently nonzero (cos from angle 10).
        serve(4'b0100, 8'd10, 2, 16'h0AF5, 16'h4AB5, 1'b0);
        ifc.req   = 4'b0100;
        ifc.angle = {4{8'd200}};
        #1;
        check("mid_grant", 32'(ifc.grant), 32'h4);
        @(negedge clk);
        @(negedge clk);
        check("mid_addr_cos", 32'(ifc.tbl_addr), 32'd8);
        resetN = 1'b0;
        #1;
        check("mid_rst_sin", 32'(ifc.sin_out), 32'd0);
        check("mid_rst_cos", 32'(ifc.cos_out), 32'd0);
        check("mid_rst_busy", 32'(ifc.busy), 32'd0);
        check("mid_rst_addr", 32'(ifc.tbl_addr), 32'd0);
        check("mid_rst_done", 32'(ifc.done), 32'd0);
        ifc.req = '0;
        @(negedge clk);
        resetN    = 1'b1;
        done_seen = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            done_seen = done_seen | ifc.done;
        end
        check("mid_no_done", 32'(done_seen), 32'd0);
        check("mid_idle", 32'(ifc.busy), 32'd0);

        // Repeated angle: cache hit when enabled, full path otherwise.
        serve(4'b0100, 8'd200, 2, 16'h0005, 16'h0031, 1'b0);
`ifdef TRIG_LOOKUP_CACHE_EN
        serve(4'b0100, 8'd200, 2, 16'h0005, 16'h0031, 1'b1);
        do_reset();
        serve(4'b0100, 8'd200, 2, 16'h0005, 16'h0031, 1'b0);
`else
        serve(4'b0100, 8'd200, 2, 16'h0005, 16'h0031, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
